// File: rtl/uart_tx_fifo_if.sv
// CPU-side bus of the UART transmitter: write strobe/data in, serial line and status word out.
interface uart_tx_fifo_if;
    logic        load;
    logic [15:0] in;
    logic        TX;
    logic [15:0] out;

    modport master (output load, output in, input TX, input out);
    modport slave  (input load, input in, output TX, output out);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fronted by a power-of-two FIFO, mapped on the HACK 16-bit I/O bus.
// Status word: [15] full, [14] busy, [13] sticky overflow, [7:0] queued entries.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          CDONE,
    uart_tx_fifo_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [OW-1:0] DEPTH     = OW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]        occ_q, occ_d;
    logic                 ovf_q, ovf_d;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic [15:0]          out_q, out_d;

    logic                 full, push, pop, bit_end;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;
    logic                 unused_in;

    // Payload bits above DATA_BITS carry no meaning on a data write.
    assign unused_in = ^bus.in[14:DATA_BITS];

    // full is taken from the pre-edge occupancy, so a pop on the same edge cannot admit a write.
    assign full     = (occ_q == DEPTH);
    assign push     = bus.load && !bus.in[15] && !full;
    assign head     = mem[rd_ptr_q];
    assign head_par = (PARITY == 1) ? ~(^head) : (^head);
    assign bit_end  = (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (occ_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    shreg_d = head;
                    par_d   = head_par;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        // A queued byte starts right away, keeping frames back-to-back.
                        if (occ_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                            tx_d    = 1'b0;
                            shreg_d = head;
                            par_d   = head_par;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        ovf_d = ovf_q;
        if (bus.load && bus.in[15]) begin
            ovf_d = 1'b0;
        end else if (bus.load && full) begin
            ovf_d = 1'b1;
        end
        out_d = {(occ_d == DEPTH), (state_d != S_IDLE) || (occ_d != '0), ovf_d,
                 5'd0, 8'(occ_d)};
    end

    // NOTE: payload storage has no reset; occupancy guards every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in[DATA_BITS-1:0];
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge CDONE) begin
        if (!CDONE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            out_q    <= out_d;
        end
    end

    assign bus.TX  = tx_q;
    assign bus.out = out_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a status-word vector table plus bit-accurate frame checks
// on four parameter sets (default, even parity, odd parity, two stop bits).
module tb_uart_tx_fifo;
    typedef struct {
        logic        load;
        logic [15:0] din;
        logic [15:0] exp_out;
        logic        exp_tx;
    } vec_t;

    logic clk   = 1'b0;
    logic cdone = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [8];

    always #5 clk = ~clk;

    uart_tx_fifo_if b0 ();
    uart_tx_fifo_if b1 ();
    uart_tx_fifo_if b2 ();
    uart_tx_fifo_if b3 ();

    uart_tx_fifo u0 (.clk(clk), .CDONE(cdone), .bus(b0));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(2))    u1 (.clk(clk), .CDONE(cdone), .bus(b1));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(1))    u2 (.clk(clk), .CDONE(cdone), .bus(b2));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u3 (.clk(clk), .CDONE(cdone), .bus(b3));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return b0.TX;
            1:       return b1.TX;
            2:       return b2.TX;
            default: return b3.TX;
        endcase
    endfunction

    function automatic logic [15:0] get_out(input int sel);
        case (sel)
            0:       return b0.out;
            1:       return b1.out;
            2:       return b2.out;
            default: return b3.out;
        endcase
    endfunction

    task automatic drive(input int sel, input logic ld, input logic [15:0] d);
        case (sel)
            0:       begin b0.load = ld; b0.in = d; end
            1:       begin b1.load = ld; b1.in = d; end
            2:       begin b2.load = ld; b2.in = d; end
            default: begin b3.load = ld; b3.in = d; end
        endcase
    endtask

    // Checks one frame cycle by cycle; skip = start-bit cycles already sampled by the caller.
    task automatic check_frame(input int sel, input int clks, input logic [7:0] data,
                               input int par, input int stops, input int skip, input string tag);
        logic        seq [16];
        logic        p;
        logic [15:0] o;
        int          n;
        int          bad;
        int          busy_bad;
        int          cyc;
        seq[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seq[1 + i] = data[i];
            p = p ^ data[i];
        end
        n = 9;
        if (par != 0) begin
            seq[n] = (par == 1) ? ~p : p;
            n++;
        end
        for (int i = 0; i < stops; i++) begin
            seq[n] = 1'b1;
            n++;
        end
        busy_bad = 0;
        for (int b = 0; b < n; b++) begin
            bad = 0;
            cyc = (b == 0) ? clks - skip : clks;
            for (int c = 0; c < cyc; c++) begin
                @(negedge clk);
                if (get_tx(sel) !== seq[b]) bad++;
                o = get_out(sel);
                if (o[14] !== 1'b1) busy_bad++;
            end
            check($sformatf("%s bit%0d wrong-cycles", tag, b), 16'(bad), 16'd0);
        end
        check($sformatf("%s busy-low-cycles", tag), 16'(busy_bad), 16'd0);
    endtask

    // Line must stay idle (TX high, status zero) for n cycles.
    task automatic watch_idle(input int sel, input int n, input string tag);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (get_tx(sel) !== 1'b1 || get_out(sel) !== 16'h0000) bad++;
        end
        check($sformatf("%s non-idle-cycles", tag), 16'(bad), 16'd0);
    endtask

    initial begin
        // Burst into depth-4 FIFO: pop on 2nd edge, 5th load fills it, 6th overflows, command clears.
        tbl[0] = '{1'b1, 16'h1201, 16'h4001, 1'b1};
        tbl[1] = '{1'b1, 16'h0002, 16'h4001, 1'b0};
        tbl[2] = '{1'b1, 16'h0003, 16'h4002, 1'b0};
        tbl[3] = '{1'b1, 16'h0004, 16'h4003, 1'b0};
        tbl[4] = '{1'b1, 16'h0005, 16'hC004, 1'b0};
        tbl[5] = '{1'b1, 16'h0006, 16'hE004, 1'b0};
        tbl[6] = '{1'b1, 16'h8000, 16'hC004, 1'b0};
        tbl[7] = '{1'b0, 16'h0000, 16'hC004, 1'b0};

        for (int s = 0; s < 4; s++) drive(s, 1'b0, 16'h0000);

        #23;
        check("in-reset tx", {15'd0, get_tx(0)}, 16'h0001);
        check("in-reset out", get_out(0), 16'h0000);
        @(negedge clk);
        cdone = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("post-reset tx%0d", s), {15'd0, get_tx(s)}, 16'h0001);
            check($sformatf("post-reset out%0d", s), get_out(s), 16'h0000);
        end

        // Single byte 0x55 at defaults.
        drive(0, 1'b1, 16'h0055);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000);
        check("t1 tx after load edge", {15'd0, get_tx(0)}, 16'h0001);
        check("t1 out after load edge", get_out(0), 16'h4001);
        check_frame(0, 217, 8'h55, 0, 1, 0, "t1");
        @(negedge clk);
        check("t1 out after frame", get_out(0), 16'h0000);
        check("t1 tx after frame", {15'd0, get_tx(0)}, 16'h0001);

        // Burst, overflow and overflow-clear through the vector table.
        for (int i = 0; i < 8; i++) begin
            drive(0, tbl[i].load, tbl[i].din);
            @(negedge clk);
            check($sformatf("tbl%0d out", i), get_out(0), tbl[i].exp_out);
            check($sformatf("tbl%0d tx", i), {15'd0, get_tx(0)}, {15'd0, tbl[i].exp_tx});
        end
        drive(0, 1'b0, 16'h0000);
        check_frame(0, 217, 8'h01, 0, 1, 7, "t2 f1");
        check_frame(0, 217, 8'h02, 0, 1, 0, "t2 f2");
        check_frame(0, 217, 8'h03, 0, 1, 0, "t2 f3");
        check_frame(0, 217, 8'h04, 0, 1, 0, "t2 f4");
        check_frame(0, 217, 8'h05, 0, 1, 0, "t2 f5");
        @(negedge clk);
        check("t2 out after burst", get_out(0), 16'h0000);

        // Command write on an idle block starts nothing.
        drive(1, 1'b1, 16'h8000);
        @(negedge clk);
        drive(1, 1'b0, 16'h0000);
        check("t3 out after command", get_out(1), 16'h0000);
        watch_idle(1, 10, "t3");

        // Even then odd parity on 0x07.
        drive(1, 1'b1, 16'h0007);
        @(negedge clk);
        drive(1, 1'b0, 16'h0000);
        check_frame(1, 4, 8'h07, 2, 1, 0, "t4 even");
        @(negedge clk);
        check("t4 even out after frame", get_out(1), 16'h0000);
        drive(2, 1'b1, 16'h0007);
        @(negedge clk);
        drive(2, 1'b0, 16'h0000);
        check_frame(2, 4, 8'h07, 1, 1, 0, "t4 odd");
        @(negedge clk);
        check("t4 odd out after frame", get_out(2), 16'h0000);

        // Two stop bits, two bytes queued back-to-back.
        drive(3, 1'b1, 16'h00A5);
        @(negedge clk);
        drive(3, 1'b1, 16'h003C);
        @(negedge clk);
        drive(3, 1'b0, 16'h0000);
        check("t5 tx start", {15'd0, get_tx(3)}, 16'h0000);
        check("t5 out", get_out(3), 16'h4001);
        check_frame(3, 4, 8'hA5, 0, 2, 1, "t5 f1");
        check_frame(3, 4, 8'h3C, 0, 2, 0, "t5 f2");
        @(negedge clk);
        check("t5 out after frames", get_out(3), 16'h0000);

        // Reset mid-DATA with two bytes queued.
        drive(0, 1'b1, 16'h0011);
        @(negedge clk);
        drive(0, 1'b1, 16'h0022);
        @(negedge clk);
        drive(0, 1'b1, 16'h0033);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000);
        check("t6 out before reset", get_out(0), 16'h4002);
        for (int c = 0; c < 300; c++) @(negedge clk);
        check("t6 tx mid-data", {15'd0, get_tx(0)}, 16'h0001);
        #2 cdone = 1'b0;
        #1;
        check("t6 async tx", {15'd0, get_tx(0)}, 16'h0001);
        check("t6 async out", get_out(0), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        cdone = 1'b1;
        watch_idle(0, 600, "t6 after reset");
        drive(0, 1'b1, 16'h005A);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000);
        check("t6 out after new load", get_out(0), 16'h4001);
        check_frame(0, 217, 8'h5A, 0, 1, 0, "t6 new");
        @(negedge clk);
        check("t6 out after new frame", get_out(0), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
